instr_decode: RTL
=================

// Module: instr_decode
// PURPOSE
//  Decode stage for the pipelined RV32I core; the upstream end of the Execute interface.
//  Accepts fetched instruction words and their PCs, splits the fields and generates immediates.
//  Reads the register file and registers opcode/func3/func7/imm/operands/PC for Execute.
//  Detects load-use hazards (inserts a bubble) and honours the Execute PC-redirect flush.
// PARAMETERS
//  DATA_W   32  operand/instruction width (matches `DataWidth)
//  ADDR_W   32  PC width (matches `AddrWidth)
//  REG_AW    5  register index width
// PORTS
//  clk           in   1       clock; all state updates on posedge
//  reset         in   1       asynchronous, active-high reset
//  instr         in   DATA_W  fetched instruction word
//  instrPC       in   ADDR_W  PC of instr
//  instrValid    in   1       instr/instrPC valid this cycle
//  instrReady    out  1       decode accepts instr this cycle (combinational)
//  rfAddr0       out  REG_AW  rs1 = instr[19:15], to register file
//  rfAddr1       out  REG_AW  rs2 = instr[24:20], to register file
//  rfData0       in   DATA_W  register file read data, port 0 (asynchronous read)
//  rfData1       in   DATA_W  register file read data, port 1
//  wbEnable      in   1       write-back strobe (Execute regWriteEnable)
//  wbAddr        in   REG_AW  write-back rd
//  wbData        in   DATA_W  write-back data (Execute regWriteData)
//  flush         in   1       PC redirect (Execute pcWriteEnable); kills the instruction in decode
//  opcode        out  7       registered opcode to Execute
//  func3         out  3       registered func3
//  func7         out  7       registered func7
//  rd            out  REG_AW  registered destination register
//  imm           out  DATA_W  registered sign-extended immediate
//  regReadData0  out  DATA_W  registered rs1 operand
//  regReadData1  out  DATA_W  registered rs2 operand
//  PC            out  ADDR_W  registered instruction PC
//  outValid      out  1       output bundle holds a real instruction (0 = bubble)
//  hazard        out  1       load-use stall active this cycle (combinational)
//  illegal       out  1       registered; 1 for one cycle when an unknown opcode was decoded
// BEHAVIOUR
//  - Reset (async): opcode=7'b0010011 (NOP: addi x0,x0,0); func3, func7, rd, imm, operands, PC = 0.
//    outValid=0, illegal=0. Reset mid-stall clears the stall immediately.
//  - Latency: an instruction accepted at edge N appears on the outputs after edge N (one cycle).
//  - Accept = instrValid & instrReady; instrReady = ~hazard | flush.
//  - Immediate by opcode:
//    I (0010011, 0000011, 1100111): sext instr[31:20].
//    S (0100011): sext {[31:25],[11:7]}.
//    B (1100011): sext {[31],[7],[30:25],[11:8],0}.
//    U (0110111, 0010111): {[31:12],12'b0}.
//    J (1101111): sext {[31],[19:12],[20],[30:21],0}.
//    R: 0.
//  - rs usage: R, S, B use rs1 and rs2. I-type and jalr use rs1 only. U and J use neither.
//  - Unused or x0 sources read as 0.
//  - Hazard (combinational): outValid & opcode==0000011 & rd!=0 & instrValid &
//    (uses rs1 & rs1==rd | uses rs2 & rs2==rd).
//    Effect: instrReady=0, the input is held upstream, the output loads a bubble (NOP, outValid=0).
//    The stall lasts exactly one cycle, because the load has then left decode.
//  - Flush has priority over hazard and accept: the next edge loads a bubble and drops the current input.
//    instrReady=1 during flush; the upstream fetch discards that word itself.
//  - No accept and no flush: the output loads a bubble. Execute never re-executes a held bundle.
//  - Unknown opcode: loads a NOP with outValid=1 and illegal=1 for that cycle.
// CONFIGURATION
//  DECODE_BYPASS_EN defined:
//    wbEnable & wbAddr!=0 & wbAddr==rs -> the operand takes wbData instead of rfData (same-cycle write-back).
//    Both ports are bypassed independently.
//  Undefined: operands come from rfData only; the register file must be write-first.
// STRUCTURE
//  - Opcode constants (OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
//    and the NOP encoding are added to Defines.v.
//  - One sub-module, imm_gen: combinational instr -> {imm, immType}.
//  - Hazard compare, bypass mux and output register stay in instr_decode.
// TESTING
//  1. Reset high mid-run -> outputs go to NOP/0 immediately, outValid=0; first instr accepted after release.
//  2. instr=32'hFFF00093 (addi x1,x0,-1) -> next cycle opcode=0010011, rd=1, imm=32'hFFFFFFFF, outValid=1.
//  3. lw x5,0(x2) then add x6,x5,x1 back-to-back:
//     hazard=1 for one cycle, one bubble with outValid=0, then the add appears.
//  4. flush=1 while beq 32'h00208463 is presented:
//     next cycle outValid=0; a flush during a hazard also yields outValid=0.
//  5. DECODE_BYPASS_EN: wbEnable=1, wbAddr=3, wbData=32'hA5A5A5A5, rfData0=0, instr reads x3
//     -> regReadData0=32'hA5A5A5A5. Without the macro -> 0.
//  6. instr opcode 7'b1111111 -> illegal=1 for one cycle, opcode=NOP; lui 32'h123450B7 -> imm=32'h12345000.

Source files
------------

// File: rtl/instr_decode_pkg.sv
// Shared RV32I decode definitions: opcode encodings, the canonical NOP and
// the immediate-format classification used by the decode stage.
package instr_decode_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [6:0]  NOP_OPCODE = NOP_INSTR[6:0];

    typedef enum logic [2:0] {
        IMM_R,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_BAD
    } immType_t;

    function automatic logic usesRs1(input immType_t t);
        return (t == IMM_R) || (t == IMM_I) || (t == IMM_S) || (t == IMM_B);
    endfunction

    function automatic logic usesRs2(input immType_t t);
        return (t == IMM_R) || (t == IMM_S) || (t == IMM_B);
    endfunction

endpackage

// File: rtl/instr_decode_imm.sv
// Combinational immediate generator: classifies the opcode into an RV32I
// format and produces the sign-extended immediate for that format.
module imm_gen
    import instr_decode_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic        [DATA_W-1:0] instr,
    output logic signed [DATA_W-1:0] imm,
    output immType_t                 immType
);

    logic signed [31:0] immRaw;

    always_comb begin
        immRaw  = '0;
        immType = IMM_BAD;
        case (instr[6:0])
            OP_I, OP_LOAD, OP_JALR: begin
                immType = IMM_I;
                immRaw  = {{20{instr[31]}}, instr[31:20]};
            end
            OP_S: begin
                immType = IMM_S;
                immRaw  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_B: begin
                immType = IMM_B;
                immRaw  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                immType = IMM_U;
                immRaw  = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                immType = IMM_J;
                immRaw  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OP_R: begin
                immType = IMM_R;
            end
            default: begin
                immType = IMM_BAD;
            end
        endcase
    end

    assign imm = DATA_W'(immRaw);

endmodule

// File: rtl/instr_decode.sv
// RV32I decode stage: field split, immediate, register operands, load-use
// stall and flush. Define DECODE_BYPASS_EN to forward same-cycle write-back.
module instr_decode
    import instr_decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] instr,
    input  logic [ADDR_W-1:0] instrPC,
    input  logic              instrValid,
    output logic              instrReady,
    output logic [REG_AW-1:0] rfAddr0,
    output logic [REG_AW-1:0] rfAddr1,
    input  logic [DATA_W-1:0] rfData0,
    input  logic [DATA_W-1:0] rfData1,
    input  logic              wbEnable,
    input  logic [REG_AW-1:0] wbAddr,
    input  logic [DATA_W-1:0] wbData,
    input  logic              flush,
    output logic [6:0]        opcode,
    output logic [2:0]        func3,
    output logic [6:0]        func7,
    output logic [REG_AW-1:0] rd,
    output logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] regReadData0,
    output logic [DATA_W-1:0] regReadData1,
    output logic [ADDR_W-1:0] PC,
    output logic              outValid,
    output logic              hazard,
    output logic              illegal
);

    logic signed [DATA_W-1:0] immDec;
    immType_t                 immType;
    logic [REG_AW-1:0]        rs1;
    logic [REG_AW-1:0]        rs2;
    logic                     useRs1;
    logic                     useRs2;
    logic                     loadPending;
    logic                     accept;
    logic [DATA_W-1:0]        operand0;
    logic [DATA_W-1:0]        operand1;

    logic [6:0]               opcode_p1,  opcode_n;
    logic [2:0]               func3_p1,   func3_n;
    logic [6:0]               func7_p1,   func7_n;
    logic [REG_AW-1:0]        rd_p1,      rd_n;
    logic signed [DATA_W-1:0] imm_p1,     imm_n;
    logic [DATA_W-1:0]        rs1Data_p1, rs1Data_n;
    logic [DATA_W-1:0]        rs2Data_p1, rs2Data_n;
    logic [ADDR_W-1:0]        pc_p1,      pc_n;
    logic                     vld_p1,     vld_n;
    logic                     illegal_p1, illegal_n;

    imm_gen #(
        .DATA_W (DATA_W)
    ) uImmGen (
        .instr   (instr),
        .imm     (immDec),
        .immType (immType)
    );

    assign rs1     = instr[15 +: REG_AW];
    assign rs2     = instr[20 +: REG_AW];
    assign rfAddr0 = rs1;
    assign rfAddr1 = rs2;
    assign useRs1  = usesRs1(immType);
    assign useRs2  = usesRs2(immType);

    // x0 and sources the format does not read are forced to zero.
    function automatic logic [DATA_W-1:0] selOperand(
        input logic              used,
        input logic [REG_AW-1:0] rs,
        input logic [DATA_W-1:0] rfData,
        input logic              wbEn,
        input logic [REG_AW-1:0] wbA,
        input logic [DATA_W-1:0] wbD
    );
        if (!used || rs == '0) begin
            return '0;
        end
`ifdef DECODE_BYPASS_EN
        if (wbEn && wbA == rs) begin
            return wbD;
        end
`endif
        return rfData;
    endfunction

`ifndef DECODE_BYPASS_EN
    logic unusedWb;
    assign unusedWb = ^{wbEnable, wbAddr, wbData};
`endif

    assign operand0 = selOperand(useRs1, rs1, rfData0, wbEnable, wbAddr, wbData);
    assign operand1 = selOperand(useRs2, rs2, rfData1, wbEnable, wbAddr, wbData);

    // A load sitting in the output register cannot supply its result yet.
    assign loadPending = vld_p1 && (opcode_p1 == OP_LOAD) && (rd_p1 != '0);
    assign hazard      = loadPending && instrValid &&
                         ((useRs1 && rs1 == rd_p1) || (useRs2 && rs2 == rd_p1));
    assign instrReady  = !hazard || flush;
    assign accept      = instrValid && instrReady && !flush;

    always_comb begin
        opcode_n   = NOP_OPCODE;
        func3_n    = '0;
        func7_n    = '0;
        rd_n       = '0;
        imm_n      = '0;
        rs1Data_n  = '0;
        rs2Data_n  = '0;
        pc_n       = '0;
        vld_n      = 1'b0;
        illegal_n  = 1'b0;
        if (accept) begin
            vld_n = 1'b1;
            pc_n  = instrPC;
            if (immType == IMM_BAD) begin
                illegal_n = 1'b1;
            end else begin
                opcode_n  = instr[6:0];
                func3_n   = instr[14:12];
                func7_n   = instr[31:25];
                rd_n      = instr[7 +: REG_AW];
                imm_n     = immDec;
                rs1Data_n = operand0;
                rs2Data_n = operand1;
            end
        end
    end

    // ---- decode -> execute register boundary ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode_p1  <= NOP_OPCODE;
            func3_p1   <= '0;
            func7_p1   <= '0;
            rd_p1      <= '0;
            imm_p1     <= '0;
            rs1Data_p1 <= '0;
            rs2Data_p1 <= '0;
            pc_p1      <= '0;
            vld_p1     <= 1'b0;
            illegal_p1 <= 1'b0;
        end else begin
            opcode_p1  <= opcode_n;
            func3_p1   <= func3_n;
            func7_p1   <= func7_n;
            rd_p1      <= rd_n;
            imm_p1     <= imm_n;
            rs1Data_p1 <= rs1Data_n;
            rs2Data_p1 <= rs2Data_n;
            pc_p1      <= pc_n;
            vld_p1     <= vld_n;
            illegal_p1 <= illegal_n;
        end
    end

    assign opcode       = opcode_p1;
    assign func3        = func3_p1;
    assign func7        = func7_p1;
    assign rd           = rd_p1;
    assign imm          = imm_p1;
    assign regReadData0 = rs1Data_p1;
    assign regReadData1 = rs2Data_p1;
    assign PC           = pc_p1;
    assign outValid     = vld_p1;
    assign illegal      = illegal_p1;

endmodule
